// File: rtl/uart_rx_buffer.sv
// UART receive buffer: unloads bytes from a UART receiver through a handshake FSM
// into a first-word-fall-through FIFO with sticky overrun and timeout flags.
module uart_rx_buffer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_empty,
    input  logic [7:0]               rx_data,
    output logic                     uld_rx_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, CAPTURE} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            sync_q1;
    logic            rx_empty_s;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            capture;
    logic            pop;
    logic            push;
    logic            drop;

    // NOTE: synchronizer resets to 1 so a reset never looks like a waiting byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1    <= 1'b1;
            rx_empty_s <= 1'b1;
        end else begin
            sync_q1    <= rx_empty;
            rx_empty_s <= sync_q1;
        end
    end

    assign capture    = (state == CAPTURE);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign pop        = rd_en && !fifo_empty;
    // A pop in the capture cycle frees the slot the incoming byte needs.
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;
    assign rd_data    = fifo_empty ? 8'h00 : mem[rd_ptr];

    // NOTE: storage is not reset; count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            uld_rx_data <= 1'b0;
            timer       <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            uld_rx_data <= 1'b0;
            // NOTE: set events are written after the clear, so the later assignment wins.
            if (clr_err) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (drop) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (!rx_empty_s) begin
                        state       <= PULSE;
                        uld_rx_data <= 1'b1;
                    end
                end
                PULSE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (rx_empty_s) begin
                        state <= CAPTURE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus a random phase,
// compared against a queue-based model of the buffer contents and sticky flags.
module tb_uart_rx_buffer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;

    logic                    clk;
    logic                    reset;
    logic                    rx_empty;
    logic [7:0]              rx_data;
    logic                    uld_rx_data;
    logic                    rd_en;
    logic [7:0]              rd_data;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [$clog2(DEPTH):0]  count;
    logic                    overrun;
    logic                    timeout_err;
    logic                    clr_err;

    uart_rx_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .uld_rx_data (uld_rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .count       (count),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks  = 0;
    int         errors  = 0;
    int         uld_cnt = 0;
    logic [7:0] model_q[$];
    logic       ovr_m;
    logic       tmo_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (uld_rx_data === 1'b1) uld_cnt++;
    endtask

    function automatic logic [7:0] head();
        return (model_q.size() > 0) ? model_q[0] : 8'h00;
    endfunction

    task automatic check_state(input string where);
        check({where, ".count"},       32'(count),       32'(model_q.size()));
        check({where, ".fifo_empty"},  32'(fifo_empty),  32'(model_q.size() == 0));
        check({where, ".fifo_full"},   32'(fifo_full),   32'(model_q.size() == DEPTH));
        check({where, ".rd_data"},     32'(rd_data),     32'(head()));
        check({where, ".overrun"},     32'(overrun),     32'(ovr_m));
        check({where, ".timeout_err"}, 32'(timeout_err), 32'(tmo_m));
    endtask

    task automatic wait_uld(input string tag);
        int n;
        n = 0;
        while (uld_rx_data !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, 32'(uld_rx_data), 32'd1);
    endtask

    // Ideal UART: present a byte, raise rx_empty one cycle after the unload pulse.
    task automatic send_byte(input logic [7:0] b, input bit pop_cap);
        int  base;
        bit  full_before;
        bit  p;
        base     = uld_cnt;
        rx_data  = b;
        rx_empty = 1'b0;
        wait_uld("uld_seen");
        tick();
        rx_empty = 1'b1;
        check("uld_one_cycle", 32'(uld_rx_data), 32'd0);
        repeat (3) tick();
        check("no_early_write", 32'(count), 32'(model_q.size()));
        if (pop_cap) begin
            check("capture_pop_head", 32'(rd_data), 32'(head()));
            rd_en = 1'b1;
        end
        tick();
        rd_en = 1'b0;
        full_before = (model_q.size() == DEPTH);
        p = pop_cap && (model_q.size() > 0);
        if (p) void'(model_q.pop_front());
        if (!full_before || p) model_q.push_back(b);
        else ovr_m = 1'b1;
        check("uld_per_byte", 32'(uld_cnt - base), 32'd1);
        check_state("send");
    endtask

    task automatic do_pop();
        check("pop_data", 32'(rd_data), 32'(head()));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_state("pop");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        ovr_m = 1'b0;
        tmo_m = 1'b0;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        ovr_m = 1'b0;
        tmo_m = 1'b0;
        check_state("clr");
    endtask

    initial begin
        int base;
        int r;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        reset    = 1'b1;
        ovr_m    = 1'b0;
        tmo_m    = 1'b0;
        @(negedge clk);
        do_reset();
        check_state("reset");
        check("reset.uld", 32'(uld_rx_data), 32'd0);

        // Single byte, then pop back to empty, then a pop on an empty FIFO.
        send_byte(8'hA5, 1'b0);
        do_pop();
        do_pop();

        // Fill to full, overrun on the ninth byte, drain in order.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h09, 1'b0);
        for (int i = 0; i < 8; i++) do_pop();
        do_clr();

        // Full FIFO with a pop in the capture cycle: legal pop plus write.
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b0);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 8; i++) do_pop();

        // Timeout: the UART never raises rx_empty after the unload pulse.
        rx_data  = 8'h5A;
        rx_empty = 1'b0;
        wait_uld("tmo_uld_seen");
        tick();
        repeat (TIMEOUT - 1) tick();
        check("tmo_not_early", 32'(timeout_err), 32'd0);
        tick();
        tmo_m = 1'b1;
        check("tmo_set", 32'(timeout_err), 32'd1);
        check("tmo_uld_low", 32'(uld_rx_data), 32'd0);
        check("tmo_count", 32'(count), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_clr", 32'(timeout_err), 32'd0);
        rx_empty = 1'b1;
        do_reset();
        check_state("tmo_reset");

        // Reset in the middle of WAIT abandons the unload and clears the FIFO.
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        rx_data  = 8'h77;
        rx_empty = 1'b0;
        wait_uld("rst_uld_seen");
        tick();
        tick();
        rx_empty = 1'b1;
        do_reset();
        check_state("rst_mid_wait");
        check("rst_uld_low", 32'(uld_rx_data), 32'd0);
        base = uld_cnt;
        repeat (6) tick();
        check("rst_no_pulse", 32'(uld_cnt - base), 32'd0);
        check_state("rst_settled");

        // Wrap-around at single-entry occupancy.
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i), 1'b0);
            do_pop();
        end

        // Random mix of bytes, capture-cycle pops, plain pops and error clears.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 4));
            if (r < 3) send_byte(8'($urandom), bit'($urandom_range(0, 1)));
            else if (r == 3) do_pop();
            else do_clr();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
